reg_bank: RTL and testbench

Parametrised multi-register bank replacing the single loadable register in the processor datapath. It holds DEPTH registers of n bits, with one write port and two registered read ports. The write port applies one of four operations to the addressed register: load, increment, shift-left or zero. It feeds the ALU operand muxes and is written from the ALU/bus result path.

---
 rtl/reg_bank_pkg.sv | 8 +
 rtl/reg_bank_nextval.sv | 19 +
 rtl/reg_bank.sv | 57 +++++
 tb/tb_reg_bank.sv | 137 +++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: write-port operation encoding shared by the register bank and its bench
package reg_bank_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_LOAD = 2'd0;
    localparam op_t OP_INC  = 2'd1;
    localparam op_t OP_SHL  = 2'd2;
    localparam op_t OP_ZERO = 2'd3;
endpackage

// File: rtl/reg_bank_nextval.sv
// reg_bank_nextval: combinational post-op value and wrap flag for one write-port operation
module reg_bank_nextval
    import reg_bank_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] cur,
    input  logic [n-1:0] in,
    input  op_t          op,
    output logic [n-1:0] next,
    output logic         wrapFlag
);
    always_comb begin
        next = op == OP_LOAD ? in :
               op == OP_INC  ? cur + n'(1) :
               op == OP_SHL  ? {cur[n-2:0], in[0]} : '0;
        wrapFlag = op == OP_INC && &cur;
    end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x n register bank, one op-based write port, two registered read ports; REG_BANK_BYPASS_EN forwards same-cycle writes to reads
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int n     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  op_t           op,
    input  logic [AW-1:0] wrAddr,
    input  logic [n-1:0]  in,
    input  logic [AW-1:0] rdAddrA,
    input  logic [AW-1:0] rdAddrB,
    output logic [n-1:0]  regOutA,
    output logic [n-1:0]  regOutB,
    output logic          wrap
);
    logic [n-1:0] regs [DEPTH];
    logic [n-1:0] next;
    logic         wrap_flag;
    logic [n-1:0] rd_a;
    logic [n-1:0] rd_b;

    reg_bank_nextval #(.n(n)) u_nextval (
        .cur     (regs[wrAddr]),
        .in      (in),
        .op      (op),
        .next    (next),
        .wrapFlag(wrap_flag)
    );

`ifdef REG_BANK_BYPASS_EN
    // a read hitting the register being written sees the post-op value
    assign rd_a = load && rdAddrA == wrAddr ? next : regs[rdAddrA];
    assign rd_b = load && rdAddrB == wrAddr ? next : regs[rdAddrB];
`else
    assign rd_a = regs[rdAddrA];
    assign rd_b = regs[rdAddrB];
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            regs    <= '{default: '0};
            regOutA <= '0;
            regOutB <= '0;
            wrap    <= 1'b0;
        end else begin
            if (load) regs[wrAddr] <= next;
            regOutA <= rd_a;
            regOutB <= rd_b;
            wrap    <= load && wrap_flag;
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: table-driven directed check of reg_bank, plus a hand-written INC wrap sequence
module tb_reg_bank;
    import reg_bank_pkg::*;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic       clr;
        logic       ld;
        logic [1:0] op;
        logic [1:0] wa;
        logic [7:0] din;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ew;
    } vec_t;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    op_t        op = OP_LOAD;
    logic [1:0] wr_addr = '0;
    logic [7:0] din = '0;
    logic [1:0] rd_a = '0;
    logic [1:0] rd_b = '0;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       wrap;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       vecs[$];

    reg_bank dut (
        .clk    (clk),
        .clear  (clear),
        .load   (load),
        .op     (op),
        .wrAddr (wr_addr),
        .in     (din),
        .rdAddrA(rd_a),
        .rdAddrB(rd_b),
        .regOutA(out_a),
        .regOutB(out_b),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic clr, input logic ld, input logic [1:0] o, input logic [1:0] wa,
                                input logic [7:0] d, input logic [1:0] ra, input logic [1:0] rb,
                                input logic [7:0] ea, input logic [7:0] eb, input logic ew);
        vec_t v;
        v.clr = clr; v.ld = ld; v.op = o; v.wa = wa; v.din = d;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step(input vec_t v);
        clear = v.clr; load = v.ld; op = v.op; wr_addr = v.wa; din = v.din; rd_a = v.ra; rd_b = v.rb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                clr ld  op       wa    din    ra    rb    expA   expB   wrap
        vecs.push_back(mk(1, 0, OP_LOAD, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd0, 8'h11, 2'd1, 2'd2, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd1, 8'h22, 2'd0, 2'd2, 8'h11, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd2, 8'h33, 2'd0, 2'd1, 8'h11, 8'h22, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd3, 8'h44, 2'd2, 2'd1, 8'h33, 8'h22, 0));
        vecs.push_back(mk(1, 0, OP_LOAD, 2'd0, 8'h00, 2'd3, 2'd0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_ZERO, 2'd0, 8'h5A, 2'd0, 2'd1, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_INC,  2'd2, 8'h00, 2'd2, 2'd3, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd2, 8'hA5, 2'd0, 2'd1, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd2, 2'd2, 8'hA5, 8'hA5, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd1, 8'hFE, 2'd2, 2'd3, 8'hA5, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_INC,  2'd1, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_INC,  2'd1, 8'h00, 2'd1, 2'd1, 8'hFF, 8'hFF, 0));
        vecs.push_back(mk(0, 1, OP_INC,  2'd1, 8'h00, 2'd2, 2'd2, 8'hA5, 8'hA5, 1));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd1, 2'd0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd3, 8'h81, 2'd1, 2'd2, 8'h00, 8'hA5, 0));
        vecs.push_back(mk(0, 1, OP_SHL,  2'd3, 8'h01, 2'd2, 2'd0, 8'hA5, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd3, 2'd3, 8'h03, 8'h03, 0));
        vecs.push_back(mk(0, 1, OP_SHL,  2'd3, 8'hFE, 2'd0, 2'd1, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd3, 2'd1, 8'h06, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd0, 8'h10, 2'd1, 2'd2, 8'h00, 8'hA5, 0));
        vecs.push_back(mk(0, 1, OP_LOAD, 2'd0, 8'h77, 2'd0, 2'd3, BYP ? 8'h77 : 8'h10, 8'h06, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd0, 2'd0, 8'h77, 8'h77, 0));
        vecs.push_back(mk(1, 1, OP_LOAD, 2'd1, 8'hFF, 2'd1, 2'd2, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd1, 2'd0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_INC,  2'd2, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, OP_INC,  2'd2, 8'h00, 2'd3, 2'd0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd2, 2'd2, 8'h02, 8'h02, 0));
        vecs.push_back(mk(0, 1, OP_INC,  2'd1, 8'h00, 2'd1, 2'd3, BYP ? 8'h01 : 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd1, 2'd1, 8'h01, 8'h01, 0));
        vecs.push_back(mk(0, 1, OP_ZERO, 2'd2, 8'hFF, 2'd2, 2'd0, BYP ? 8'h00 : 8'h02, 8'h00, 0));
        vecs.push_back(mk(0, 0, OP_LOAD, 2'd0, 8'h00, 2'd2, 2'd1, 8'h00, 8'h01, 0));

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i]);
            chk($sformatf("row%0d.regOutA", i), out_a, vecs[i].ea);
            chk($sformatf("row%0d.regOutB", i), out_b, vecs[i].eb);
            chk($sformatf("row%0d.wrap", i), {7'd0, wrap}, {7'd0, vecs[i].ew});
        end

        // wrap must drop straight back to 0 on a following non-wrapping INC
        step(mk(0, 1, OP_LOAD, 2'd3, 8'hFF, 2'd0, 2'd0, 8'h00, 8'h00, 0));
        chk("seq.wrap_after_load", {7'd0, wrap}, 8'h00);
        step(mk(0, 1, OP_INC, 2'd3, 8'h00, 2'd3, 2'd0, 8'h00, 8'h00, 0));
        chk("seq.wrap_after_inc1", {7'd0, wrap}, 8'h01);
        step(mk(0, 1, OP_INC, 2'd3, 8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 0));
        chk("seq.wrap_after_inc2", {7'd0, wrap}, 8'h00);
        step(mk(0, 0, OP_INC, 2'd3, 8'h00, 2'd3, 2'd1, 8'h00, 8'h00, 0));
        chk("seq.reg3_after_two_inc", out_a, 8'h01);
        chk("seq.reg1_untouched", out_b, 8'h01);
        chk("seq.wrap_idle", {7'd0, wrap}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
